// File: rtl/mem_stage_pkg.sv
// ---------------------------------------------------------------------------
// mem_stage_pkg
// Shared constants and types for the memory-stage store buffer.
//   SB_DEPTH_DEFAULT : default number of buffered store entries
//   SB_*_W           : entry field widths (word address, data, byte lanes)
//   sb_state_t       : drain FSM state encoding
// Ports: none (package).
// ---------------------------------------------------------------------------
package mem_stage_pkg;

    localparam int SB_DEPTH_DEFAULT = 4;
    localparam int SB_ADDR_W        = 32;
    localparam int SB_WADDR_W       = 30;
    localparam int SB_DATA_W        = 32;
    localparam int SB_BE_W          = 4;

    localparam logic [SB_BE_W-1:0] SB_BE_NONE = 4'b0000;
    localparam logic [SB_BE_W-1:0] SB_BE_FULL = 4'b1111;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_WAIT_ACK = 1'b1
    } sb_state_t;

endpackage

// File: rtl/store_buffer_fifo.sv
// ---------------------------------------------------------------------------
// store_buffer_fifo
// Circular entry storage for the store buffer. Entries hold the word
// address, data and byte-lane mask of one store; the head is popped only
// after memory accepts it. All entries are exported so the parent can run
// the load hazard compare in age order starting at o_rd_ptr.
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   i_push, i_pop     append at tail / remove head (caller guarantees legality)
//   i_waddr/i_data/i_be  entry written on push
//   o_count           occupied entries
//   o_rd_ptr          index of the oldest entry
//   o_waddr/o_data/o_be  raw storage arrays
// ---------------------------------------------------------------------------
module store_buffer_fifo
    import mem_stage_pkg::*;
#(
    parameter int  DEPTH = SB_DEPTH_DEFAULT,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic [SB_WADDR_W-1:0] i_waddr,
    input  logic [SB_DATA_W-1:0]  i_data,
    input  logic [SB_BE_W-1:0]    i_be,
    output logic [CNT_W-1:0]      o_count,
    output logic [PTR_W-1:0]      o_rd_ptr,
    output logic [SB_WADDR_W-1:0] o_waddr [DEPTH],
    output logic [SB_DATA_W-1:0]  o_data  [DEPTH],
    output logic [SB_BE_W-1:0]    o_be    [DEPTH]
);

    logic [SB_WADDR_W-1:0] r_waddr [DEPTH];
    logic [SB_DATA_W-1:0]  r_data  [DEPTH];
    logic [SB_BE_W-1:0]    r_be    [DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;

    // Storage, pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_waddr[i] <= '0;
                r_data[i]  <= '0;
                r_be[i]    <= '0;
            end
        end else begin
            if (i_push) begin
                r_waddr[r_wr_ptr] <= i_waddr;
                r_data[r_wr_ptr]  <= i_data;
                r_be[r_wr_ptr]    <= i_be;
                r_wr_ptr          <= r_wr_ptr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count  = r_count;
    assign o_rd_ptr = r_rd_ptr;
    assign o_waddr  = r_waddr;
    assign o_data   = r_data;
    assign o_be     = r_be;

endmodule

// File: rtl/store_buffer.sv
// ---------------------------------------------------------------------------
// store_buffer
// Posted-write buffer between the memory stage and data memory. Stores are
// queued in store_buffer_fifo and drained one at a time by a two-state FSM
// (IDLE / WAIT_ACK). Loads whose word address matches any occupied entry
// (including the one currently in flight) are stalled.
// Optional build macro STORE_FWD_EN: when defined, a load whose youngest
// matching entry writes all four lanes is served from that entry instead of
// stalling (LoadFwdValid/LoadFwdData); otherwise those outputs are tied 0.
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   StoreValid/StoreReady/StoreAddr/StoreData/ByteEnable  store input
//   LoadValid/LoadAddr/LoadStall/LoadFwdValid/LoadFwdData load hazard check
//   MemReq/MemAck/MemAddr/MemWData/MemByteEn              memory write port
//   Empty, Count                        status
// ---------------------------------------------------------------------------
module store_buffer
    import mem_stage_pkg::*;
#(
    parameter int  DEPTH = SB_DEPTH_DEFAULT,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 StoreValid,
    output logic                 StoreReady,
    input  logic [SB_ADDR_W-1:0] StoreAddr,
    input  logic [SB_DATA_W-1:0] StoreData,
    input  logic [SB_BE_W-1:0]   ByteEnable,
    input  logic                 LoadValid,
    input  logic [SB_ADDR_W-1:0] LoadAddr,
    output logic                 LoadStall,
    output logic                 LoadFwdValid,
    output logic [SB_DATA_W-1:0] LoadFwdData,
    output logic                 MemReq,
    input  logic                 MemAck,
    output logic [SB_ADDR_W-1:0] MemAddr,
    output logic [SB_DATA_W-1:0] MemWData,
    output logic [SB_BE_W-1:0]   MemByteEn,
    output logic                 Empty,
    output logic [CNT_W-1:0]     Count
);

    sb_state_t             r_state;
    sb_state_t             w_next_state;
    logic                  r_mem_req;
    logic [SB_WADDR_W-1:0] r_mem_waddr;
    logic [SB_DATA_W-1:0]  r_mem_wdata;
    logic [SB_BE_W-1:0]    r_mem_be;

    logic                  w_push;
    logic                  w_pop;
    logic                  w_latch;
    logic                  w_store_ready;
    logic [CNT_W-1:0]      w_count;
    logic [PTR_W-1:0]      w_rd_ptr;
    logic [SB_WADDR_W-1:0] w_waddr [DEPTH];
    logic [SB_DATA_W-1:0]  w_data  [DEPTH];
    logic [SB_BE_W-1:0]    w_be    [DEPTH];
    logic [DEPTH-1:0]      w_hit;
    logic                  w_any_match;
    logic                  w_unused_addr_lsb;

    // Byte offsets do not take part in word matching or in the memory address.
    assign w_unused_addr_lsb = ^{StoreAddr[1:0], LoadAddr[1:0]};

    // A full buffer refuses stores even if the head pops this cycle; empty-lane stores are accepted but dropped.
    assign w_store_ready = (w_count != CNT_W'(DEPTH));
    assign w_push        = StoreValid && w_store_ready && (ByteEnable != SB_BE_NONE);

    store_buffer_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .i_push   (w_push),
        .i_pop    (w_pop),
        .i_waddr  (StoreAddr[SB_ADDR_W-1:2]),
        .i_data   (StoreData),
        .i_be     (ByteEnable),
        .o_count  (w_count),
        .o_rd_ptr (w_rd_ptr),
        .o_waddr  (w_waddr),
        .o_data   (w_data),
        .o_be     (w_be)
    );

    // Drain FSM next state: start on any occupied entry, pop the head when memory acknowledges.
    always_comb begin
        w_next_state = r_state;
        w_latch      = 1'b0;
        w_pop        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_count != CNT_W'(0)) begin
                    w_next_state = ST_WAIT_ACK;
                    w_latch      = 1'b1;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_WAIT_ACK: begin
                if (MemAck) begin
                    w_next_state = ST_IDLE;
                    w_pop        = 1'b1;
                end else begin
                    w_next_state = ST_WAIT_ACK;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Drain FSM state, registered MemReq and the memory-side entry latch.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_mem_req   <= 1'b0;
            r_mem_waddr <= '0;
            r_mem_wdata <= '0;
            r_mem_be    <= '0;
        end else begin
            r_state   <= w_next_state;
            r_mem_req <= (w_next_state == ST_WAIT_ACK);
            if (w_latch) begin
                r_mem_waddr <= w_waddr[w_rd_ptr];
                r_mem_wdata <= w_data[w_rd_ptr];
                r_mem_be    <= w_be[w_rd_ptr];
            end
        end
    end

    // Per-entry word match, indexed by age (k = 0 is the oldest entry).
    always_comb begin
        w_hit = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_hit[k] = (CNT_W'(k) < w_count) &&
                       (w_waddr[w_rd_ptr + PTR_W'(k)] == LoadAddr[SB_ADDR_W-1:2]);
        end
    end

    assign w_any_match = |w_hit;

`ifdef STORE_FWD_EN
    logic [SB_BE_W-1:0]   w_young_be;
    logic [SB_DATA_W-1:0] w_young_data;
    logic                 w_fwd;

    // Walk oldest to youngest so the last hit wins: that is the youngest matching store.
    always_comb begin
        w_young_be   = '0;
        w_young_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_young_be   = w_hit[k] ? w_be[w_rd_ptr + PTR_W'(k)]   : w_young_be;
            w_young_data = w_hit[k] ? w_data[w_rd_ptr + PTR_W'(k)] : w_young_data;
        end
    end

    assign w_fwd        = LoadValid && w_any_match && (w_young_be == SB_BE_FULL);
    assign LoadFwdValid = w_fwd;
    assign LoadFwdData  = w_fwd ? w_young_data : 32'h0000_0000;
    assign LoadStall    = LoadValid && w_any_match && !w_fwd;
`else
    assign LoadFwdValid = 1'b0;
    assign LoadFwdData  = 32'h0000_0000;
    assign LoadStall    = LoadValid && w_any_match;
`endif

    assign StoreReady = w_store_ready;
    assign MemReq     = r_mem_req;
    assign MemAddr    = {r_mem_waddr, 2'b00};
    assign MemWData   = r_mem_wdata;
    assign MemByteEn  = r_mem_be;
    assign Count      = w_count;
    assign Empty      = (w_count == CNT_W'(0)) && (r_state == ST_IDLE);

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered store entries (power of two, 2..8).
REQ-002 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have store-side ports:
- StoreValid  in  1  store request.
- StoreReady  out  1  buffer can accept a store.
- StoreAddr  in  32  byte address.
- StoreData  in  32  write data, already lane-aligned.
- ByteEnable  in  4  lane mask from the byte-enable stage.
REQ-004 SHALL have load-check ports:
- LoadValid  in  1  load in memory stage.
- LoadAddr  in  32  load byte address.
- LoadStall  out  1  load must wait.
- LoadFwdValid  out  1  forwarded data is valid.
- LoadFwdData  out  32  forwarded word.
REQ-005 SHALL have memory-side ports:
- MemReq  out  1  write request.
- MemAck  in  1  memory accepted the write.
- MemAddr  out  32  word-aligned address.
- MemWData  out  32  write data.
- MemByteEn  out  4  lane mask.
REQ-006 SHALL have status ports:
- Empty  out  1  no entries and no write in flight.
- Count  out  $clog2(DEPTH)+1  occupied entries.

Function
REQ-007 SHALL drive StoreReady = (Count != DEPTH); a push occurs when StoreValid && StoreReady at a rising edge.
REQ-008 SHALL accept a store with ByteEnable == 4'b0000 (StoreReady honoured) without allocating an entry.
REQ-009 SHALL store StoreAddr[31:2], StoreData and ByteEnable per entry, drained strictly in FIFO order.
REQ-010 SHALL implement drain FSM IDLE/WAIT_ACK:
- IDLE -> WAIT_ACK when Count != 0, latching the head entry into MemAddr/MemWData/MemByteEn.
- WAIT_ACK -> IDLE on MemAck, popping the head in the same edge.
REQ-011 SHALL drive MemReq registered, high exactly in WAIT_ACK, with Mem* outputs stable until MemAck; MemAck outside WAIT_ACK SHALL be ignored.
REQ-012 SHALL assert MemReq no earlier than one cycle after the push edge into an empty buffer; sustained throughput SHALL be at most one store per two cycles.
REQ-013 SHALL count the in-flight head entry in Count until popped; simultaneous push and pop SHALL leave Count unchanged.
REQ-014 SHALL treat a full buffer as non-accepting even when a pop occurs in the same cycle.
REQ-015 SHALL compute LoadStall combinationally as LoadValid && (any occupied entry with address[31:2] == LoadAddr[31:2]), except where REQ-019 forwards.
REQ-016 SHALL drive LoadFwdValid = 0 and LoadFwdData = 0 whenever forwarding does not apply.
REQ-017 SHALL drive Empty = (Count == 0) && (state == IDLE).

Reset
REQ-018 SHALL, on reset, discard all entries, enter IDLE, and drive MemReq = 0, MemAddr/MemWData = 0, MemByteEn = 0, Count = 0, Empty = 1, StoreReady = 1; reset mid-transaction SHALL drop MemReq on the next cycle regardless of MemAck.

Configuration
REQ-019 SHALL, with STORE_FWD_EN defined, forward the youngest matching entry when its ByteEnable == 4'b1111: LoadFwdValid = 1, LoadFwdData = that entry's data, LoadStall = 0; partial youngest matches SHALL stall. Without STORE_FWD_EN, any match SHALL stall, and LoadFwdValid/LoadFwdData SHALL be tied to 0.

Structure
REQ-020 SHALL place the DEPTH default, FSM state encodings and entry field widths in shared package mem_stage_pkg.
REQ-021 SHALL place the entry storage and pointers in sub-module store_buffer_fifo; the FSM, hazard compare and forwarding logic SHALL reside in store_buffer.

Verification
REQ-022 Bench: reset, then push addr 0x100, data 0xAABBCCDD, BE 4'b1111, with MemAck tied high -> MemReq high 1 cycle later with MemAddr 0x100, MemByteEn 4'hF; Empty = 1 after ack.
REQ-023 Bench: MemAck low, push 4 stores -> StoreReady = 0, Count = 4, 5th store held; one MemAck -> Count = 3, StoreReady = 1.
REQ-024 Bench: pending store 0x204 with BE 4'b0100, LoadAddr 0x206 -> LoadStall = 1; LoadAddr 0x208 -> LoadStall = 0.
REQ-025 Bench (STORE_FWD_EN): stores 0x300/BE 4'hF/0x11111111, then 0x300/BE 4'hF/0x22222222, load 0x300 -> LoadFwdData = 0x22222222, LoadStall = 0; without the macro -> LoadStall = 1.
REQ-026 Bench: push with ByteEnable 4'b0000 -> Count stays 0, MemReq stays 0.
REQ-027 Bench: reset asserted in WAIT_ACK with MemAck low -> MemReq = 0 and Count = 0 next cycle.
